// File: rtl/rholang_process_dispatcher.sv
// Program decoder and process dispatcher: loads {type,payload} records
// into a FIFO, then hands them to free FPUs and tracks their completion.
// Ports: clk, reset (sync, active-high); prog_word/prog_valid/prog_ready
// load stream; start; init_* dispatch handshake; fpu_busy, fpu_done;
// active_count, queue_level, exec_active, exec_done, error status.
// Option: DISPATCHER_ROUND_ROBIN_EN selects round-robin FPU search.
module rholang_process_dispatcher #(
  parameter int NUM_FPUS     = 16,
  parameter int FPU_ID_WIDTH = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TYPE_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   prog_word,
  input  logic                          prog_valid,
  output logic                          prog_ready,
  input  logic                          start,
  output logic [FPU_ID_WIDTH-1:0]       init_fpu_id,
  output logic [TYPE_WIDTH-1:0]         init_process_type,
  output logic [31:0]                   init_process_data,
  output logic                          init_valid,
  input  logic                          init_ready,
  input  logic [NUM_FPUS-1:0]           fpu_busy,
  input  logic [NUM_FPUS-1:0]           fpu_done,
  output logic [FPU_ID_WIDTH:0]         active_count,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level,
  output logic                          exec_active,
  output logic                          exec_done,
  output logic                          error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TYPE_WIDTH + 32;
  localparam int CW = FPU_ID_WIDTH + 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ARMED,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   level;
  logic [AW:0]   remain;
  logic          full;
  logic          push;

  logic                  hdr_q, hdr_d;
  logic [TYPE_WIDTH-1:0] htype_q, htype_d;
  logic                  err_q, err_d;

  logic [NUM_FPUS-1:0] alloc_q, alloc_d;
  logic [CW-1:0]       act_q, act_d;

  logic                    iv_q, iv_d;
  logic [FPU_ID_WIDTH-1:0] id_q, id_d;
  logic [TYPE_WIDTH-1:0]   ityp_q, ityp_d;
  logic [31:0]             idat_q, idat_d;
  logic                    done_q, done_d;

`ifdef DISPATCHER_ROUND_ROBIN_EN
  logic [FPU_ID_WIDTH-1:0] last_q, last_d;
`endif

  logic                    accept;
  logic                    fire;
  logic [3:0]              opcode;
  logic [NUM_FPUS-1:0]     grant_oh;
  logic [NUM_FPUS-1:0]     done_hit;
  logic [NUM_FPUS-1:0]     cand;
  logic [CW-1:0]           ndone;
  logic                    pick_ok;
  logic [FPU_ID_WIDTH-1:0] pick_id;

  assign level  = wr_q - rd_q;
  assign full   = (level == (AW+1)'(FIFO_DEPTH));
  assign opcode = prog_word[31:28];

  assign prog_ready = (state_q == S_LOAD) && !full && !reset;
  assign accept     = prog_valid && prog_ready;
  assign fire       = iv_q && init_ready;

  assign init_valid        = iv_q;
  assign init_fpu_id       = id_q;
  assign init_process_type = ityp_q;
  assign init_process_data = idat_q;
  assign active_count      = act_q;
  assign queue_level       = level;
  assign exec_active       = (state_q == S_RUN);
  assign exec_done         = done_q;
  assign error             = err_q;

  // The FPU being granted this cycle is excluded so the next
  // descriptor can be presented right behind the accept.
  assign grant_oh = NUM_FPUS'(fire) << id_q;
  assign done_hit = fpu_done & alloc_q;
  assign cand     = ~fpu_busy & ~alloc_q & ~grant_oh;
  assign rd_d     = rd_q + (AW+1)'(fire);
  assign remain   = wr_q - rd_d;

  always_comb begin
    ndone = '0;
    for (int i = 0; i < NUM_FPUS; i++) begin
      ndone = ndone + CW'(done_hit[i]);
    end
  end

  always_comb begin
    pick_ok = 1'b0;
    pick_id = '0;
`ifdef DISPATCHER_ROUND_ROBIN_EN
    for (int k = 0; k < NUM_FPUS; k++) begin
      if (!pick_ok && cand[(int'(last_q) + 1 + k) % NUM_FPUS]) begin
        pick_ok = 1'b1;
        pick_id = FPU_ID_WIDTH'((int'(last_q) + 1 + k) % NUM_FPUS);
      end
    end
`else
    for (int i = NUM_FPUS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_ok = 1'b1;
        pick_id = FPU_ID_WIDTH'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    wr_d    = wr_q;
    hdr_d   = hdr_q;
    htype_d = htype_q;
    err_d   = err_q;
    alloc_d = (alloc_q & ~done_hit) | grant_oh;
    act_d   = act_q + CW'(fire) - ndone;
    iv_d    = iv_q && !fire;
    id_d    = id_q;
    ityp_d  = ityp_q;
    idat_d  = idat_q;
    done_d  = 1'b0;
`ifdef DISPATCHER_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (hdr_q) begin
            hdr_d = 1'b0;
            if (opcode == 4'hF) begin
              err_d   = 1'b1;
              state_d = S_ARMED;
            end else begin
              push = 1'b1;
            end
          end else if (opcode == 4'h1) begin
            hdr_d   = 1'b1;
            htype_d = prog_word[27 -: TYPE_WIDTH];
          end else if (opcode == 4'hF) begin
            state_d = S_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
        wr_d = wr_q + (AW+1)'(push);
      end
      S_ARMED: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if ((!iv_q || fire) && remain != '0 && pick_ok) begin
          iv_d             = 1'b1;
          id_d             = pick_id;
          {ityp_d, idat_d} = mem[rd_d[AW-1:0]];
`ifdef DISPATCHER_ROUND_ROBIN_EN
          last_d           = pick_id;
`endif
        end
        if (remain == '0 && !iv_d && act_d == '0) begin
          state_d = S_LOAD;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= {htype_q, prog_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      wr_q    <= '0;
      rd_q    <= '0;
      hdr_q   <= 1'b0;
      htype_q <= '0;
      err_q   <= 1'b0;
      alloc_q <= '0;
      act_q   <= '0;
      iv_q    <= 1'b0;
      id_q    <= '0;
      ityp_q  <= '0;
      idat_q  <= '0;
      done_q  <= 1'b0;
`ifdef DISPATCHER_ROUND_ROBIN_EN
      // First search after reset begins at FPU 0.
      last_q  <= FPU_ID_WIDTH'(NUM_FPUS - 1);
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      hdr_q   <= hdr_d;
      htype_q <= htype_d;
      err_q   <= err_d;
      alloc_q <= alloc_d;
      act_q   <= act_d;
      iv_q    <= iv_d;
      id_q    <= id_d;
      ityp_q  <= ityp_d;
      idat_q  <= idat_d;
      done_q  <= done_d;
`ifdef DISPATCHER_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_rholang_process_dispatcher.sv
// Directed bench for rholang_process_dispatcher.
// Loads records, dispatches them and checks status against hand values.
module tb_rholang_process_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] prog_word;
  logic        prog_valid;
  logic        prog_ready;
  logic        start;
  logic [3:0]  init_fpu_id;
  logic [3:0]  init_process_type;
  logic [31:0] init_process_data;
  logic        init_valid;
  logic        init_ready;
  logic [15:0] fpu_busy;
  logic [15:0] fpu_done;
  logic [4:0]  active_count;
  logic [3:0]  queue_level;
  logic        exec_active;
  logic        exec_done;
  logic        error;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rholang_process_dispatcher dut (
    .clk(clk),
    .reset(reset),
    .prog_word(prog_word),
    .prog_valid(prog_valid),
    .prog_ready(prog_ready),
    .start(start),
    .init_fpu_id(init_fpu_id),
    .init_process_type(init_process_type),
    .init_process_data(init_process_data),
    .init_valid(init_valid),
    .init_ready(init_ready),
    .fpu_busy(fpu_busy),
    .fpu_done(fpu_done),
    .active_count(active_count),
    .queue_level(queue_level),
    .exec_active(exec_active),
    .exec_done(exec_done),
    .error(error)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    prog_word  = w;
    prog_valid = 1'b1;
    #1;
    n = 0;
    while (!prog_ready && n < 20) begin
      tick();
      n++;
    end
    if (!prog_ready) chk("send_timeout", 0, 1);
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_iv();
    int n;
    n = 0;
    while (!init_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_iv", init_valid, 1);
  endtask

  initial begin
    reset      = 1'b1;
    prog_word  = '0;
    prog_valid = 1'b0;
    start      = 1'b0;
    init_ready = 1'b0;
    fpu_busy   = '0;
    fpu_done   = '0;
    tick();
    tick();
    #1;
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_init_valid", init_valid, 0);
    chk("rst_active", active_count, 0);
    chk("rst_level", queue_level, 0);
    chk("rst_exec_active", exec_active, 0);
    chk("rst_exec_done", exec_done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", prog_ready, 1);

    // three records, consecutive grants
    send(32'h1200_0000);
    send(32'h0000_000A);
    chk("level_1", queue_level, 1);
    send(32'h1300_0000);
    send(32'h0000_000B);
    send(32'h1400_0000);
    send(32'h0000_000C);
    chk("level_3", queue_level, 3);
    send(32'hF000_0000);
    chk("armed_ready", prog_ready, 0);
    chk("armed_active", exec_active, 0);
    init_ready = 1'b1;
    pulse_start();
    chk("run_active", exec_active, 1);
    chk("run_iv_first", init_valid, 0);
    tick();
    chk("g0_valid", init_valid, 1);
    chk("g0_id", init_fpu_id, 0);
    chk("g0_type", init_process_type, 2);
    chk("g0_data", init_process_data, 32'hA);
    tick();
    chk("g1_valid", init_valid, 1);
    chk("g1_id", init_fpu_id, 1);
    chk("g1_data", init_process_data, 32'hB);
    chk("g1_active", active_count, 1);
    tick();
    chk("g2_id", init_fpu_id, 2);
    chk("g2_type", init_process_type, 4);
    chk("g2_data", init_process_data, 32'hC);
    chk("g2_active", active_count, 2);
    tick();
    chk("g3_valid", init_valid, 0);
    chk("g3_active", active_count, 3);
    chk("g3_level", queue_level, 0);
    fpu_done = 16'h0020;
    tick();
    fpu_done = '0;
    chk("stray_done", active_count, 3);
    chk("stray_exec", exec_active, 1);
    fpu_done = 16'h0007;
    tick();
    fpu_done = '0;
    chk("done_active", active_count, 0);
    chk("done_pulse", exec_done, 1);
    chk("done_exec_low", exec_active, 0);
    tick();
    chk("done_pulse_end", exec_done, 0);
    chk("back_load", prog_ready, 1);
    init_ready = 1'b0;

    // fill the FIFO
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(32'h1100_0000);
      send(32'h0000_0100 + 32'(i));
    end
    chk("full_level", queue_level, 8);
    prog_word  = 32'h1100_0000;
    prog_valid = 1'b1;
    #1;
    chk("full_ready", prog_ready, 0);
    tick();
    chk("full_level_hold", queue_level, 8);
    prog_valid = 1'b0;

    // illegal word, then END with pending header
    do_reset();
    send(32'h5000_0000);
    chk("illegal_err", error, 1);
    chk("illegal_level", queue_level, 0);
    send(32'h1100_0000);
    send(32'h0000_0055);
    chk("after_err_level", queue_level, 1);
    chk("err_sticky", error, 1);
    send(32'h1700_0000);
    send(32'hF000_0000);
    chk("end_pend_armed", prog_ready, 0);
    chk("end_pend_level", queue_level, 1);
    chk("end_pend_err", error, 1);
    pulse_start();
    wait_iv();
    chk("err_rec_type", init_process_type, 1);
    chk("err_rec_data", init_process_data, 32'h55);

    // busy FPUs force reuse of FPU 0
    do_reset();
    chk("busy_rst_err", error, 0);
    fpu_busy = 16'hFFFE;
    send(32'h1600_0000);
    send(32'h0000_0060);
    send(32'h1700_0000);
    send(32'h0000_0070);
    send(32'hF000_0000);
    init_ready = 1'b1;
    pulse_start();
    tick();
    chk("b0_valid", init_valid, 1);
    chk("b0_id", init_fpu_id, 0);
    chk("b0_data", init_process_data, 32'h60);
    tick();
    chk("b_stall_iv", init_valid, 0);
    chk("b_stall_act", active_count, 1);
    tick();
    tick();
    chk("b_stall2_iv", init_valid, 0);
    chk("b_stall2_lvl", queue_level, 1);
    fpu_done = 16'h0001;
    tick();
    fpu_done = '0;
    chk("b_done_act", active_count, 0);
    chk("b_done_nodone", exec_done, 0);
    tick();
    chk("b1_valid", init_valid, 1);
    chk("b1_id", init_fpu_id, 0);
    chk("b1_type", init_process_type, 7);
    chk("b1_data", init_process_data, 32'h70);
    tick();
    chk("b1_act", active_count, 1);
    fpu_done = 16'h0001;
    tick();
    fpu_done = '0;
    chk("b_exec_done", exec_done, 1);
    fpu_busy   = '0;
    init_ready = 1'b0;

    // reset mid-run with a pending init
    do_reset();
    send(32'h1300_0000);
    send(32'h0000_0033);
    send(32'hF000_0000);
    pulse_start();
    tick();
    chk("mr_valid", init_valid, 1);
    reset = 1'b1;
    tick();
    chk("mr_iv", init_valid, 0);
    chk("mr_id", init_fpu_id, 0);
    chk("mr_data", init_process_data, 0);
    chk("mr_type", init_process_type, 0);
    chk("mr_level", queue_level, 0);
    chk("mr_active", exec_active, 0);
    chk("mr_ready", prog_ready, 0);
    reset = 1'b0;
    #1;
    chk("mr_load", prog_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 want=1");
    $fatal(1, "timeout");
  end

endmodule
